// File: rtl/sw_pkg.sv
// Shared constants and types for the Smith-Waterman symbol feeder.
package sw_pkg;

  localparam int unsigned LEN_REF_DEF   = 64;
  localparam int unsigned LEN_QUERY_DEF = 48;

  localparam logic [1:0] NT_A = 2'd0;
  localparam logic [1:0] NT_C = 2'd1;
  localparam logic [1:0] NT_G = 2'd2;
  localparam logic [1:0] NT_T = 2'd3;

  typedef enum logic [2:0] {
    LOAD_REF,
    LOAD_QRY,
    STREAM,
    GAP,
    WAIT_DONE
  } fsm_state_t;

endpackage

// File: rtl/sw_feeder_if.sv
// Host character input and aligner symbol stream of the feeder.
interface sw_feeder_if;
  logic       in_valid;
  logic [7:0] in_char;
  logic       in_ready;
  logic       sw_valid;
  logic [1:0] sw_data_ref;
  logic [1:0] sw_data_query;
  logic       sw_finish;

  modport master (
    output in_valid, in_char, sw_finish,
    input  in_ready, sw_valid, sw_data_ref, sw_data_query
  );

  modport slave (
    input  in_valid, in_char, sw_finish,
    output in_ready, sw_valid, sw_data_ref, sw_data_query
  );
endinterface

// File: rtl/sw_feeder_nt_encoder.sv
// ASCII nucleotide to 2-bit code; anything outside A/C/G/T (either case) is flagged.
module nt_encoder
  import sw_pkg::*;
(
  input  logic [7:0] ch,
  output logic [1:0] code,
  output logic       illegal
);

  always_comb begin
    code    = NT_A;
    illegal = 1'b0;
    case (ch)
      8'h41, 8'h61: code = NT_A;
      8'h43, 8'h63: code = NT_C;
      8'h47, 8'h67: code = NT_G;
      8'h54, 8'h74: code = NT_T;
      default:      illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/sw_feeder.sv
// Buffers one reference/query pair from the host, then streams it to the aligner
// and waits for the aligner's finish pulse before accepting the next pair.
module sw_feeder
  import sw_pkg::*;
#(
  parameter int unsigned LEN_REF   = LEN_REF_DEF,
  parameter int unsigned LEN_QUERY = LEN_QUERY_DEF
) (
  input  logic         clk,
  input  logic         reset,
  sw_feeder_if.slave   bus,
  output logic         busy,
  output logic         err,
  output logic [7:0]   pair_cnt
);

  localparam int unsigned IW = (LEN_REF > 1) ? $clog2(LEN_REF) : 1;

  fsm_state_t    state;
  logic [IW-1:0] idx;
  logic [1:0]    ref_mem [LEN_REF];
  logic [1:0]    qry_mem [LEN_QUERY];

  logic [1:0]    code_c;
  logic          illegal_c;
  logic          xfer_c;
  logic          last_ref_c;
  logic          last_qry_c;
  logic [IW-1:0] idx_nxt_c;
  logic [1:0]    ref_rd_c;
  logic [1:0]    qry_rd_c;
  logic [1:0]    qry_first_c;

  nt_encoder u_enc (
    .ch      (bus.in_char),
    .code    (code_c),
    .illegal (illegal_c)
  );

  assign xfer_c     = bus.in_valid & bus.in_ready;
  assign last_ref_c = (idx == IW'(LEN_REF - 1));
  assign last_qry_c = (idx == IW'(LEN_QUERY - 1));
  assign idx_nxt_c  = idx + IW'(1);

  // Look-ahead reads: the registered outputs present symbol idx+1 in the next cycle.
  assign ref_rd_c    = ref_mem[idx_nxt_c];
  assign qry_rd_c    = (32'(idx_nxt_c) < LEN_QUERY) ? qry_mem[idx_nxt_c] : NT_A;
  assign qry_first_c = (LEN_QUERY == 1) ? code_c : qry_mem[0];

  // Symbol buffers carry no reset; a pair is always fully reloaded before streaming.
  always_ff @(posedge clk) begin
    if (xfer_c && state == LOAD_REF) ref_mem[idx] <= code_c;
    if (xfer_c && state == LOAD_QRY) qry_mem[idx] <= code_c;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= LOAD_REF;
      idx               <= '0;
      bus.in_ready      <= 1'b0;
      bus.sw_valid      <= 1'b0;
      bus.sw_data_ref   <= NT_A;
      bus.sw_data_query <= NT_A;
      busy              <= 1'b0;
      err               <= 1'b0;
      pair_cnt          <= '0;
    end else begin
      case (state)
        LOAD_REF: begin
          bus.in_ready <= 1'b1;
          if (xfer_c) begin
            busy <= 1'b1;
            // The first character of a pair restarts the sticky error.
            err  <= (idx == '0) ? illegal_c : (err | illegal_c);
            if (last_ref_c) begin
              state <= LOAD_QRY;
              idx   <= '0;
            end else begin
              idx <= idx_nxt_c;
            end
          end
        end
        LOAD_QRY: begin
          if (xfer_c) begin
            err <= err | illegal_c;
            if (last_qry_c) begin
              state             <= STREAM;
              idx               <= '0;
              bus.in_ready      <= 1'b0;
              bus.sw_valid      <= 1'b1;
              bus.sw_data_ref   <= ref_mem[0];
              bus.sw_data_query <= qry_first_c;
            end else begin
              idx <= idx_nxt_c;
            end
          end
        end
        STREAM: begin
          if (last_ref_c) begin
            state             <= GAP;
            idx               <= '0;
            bus.sw_valid      <= 1'b0;
            bus.sw_data_ref   <= NT_A;
            bus.sw_data_query <= NT_A;
          end else begin
            idx               <= idx_nxt_c;
            bus.sw_data_ref   <= ref_rd_c;
            bus.sw_data_query <= qry_rd_c;
          end
        end
        GAP: state <= WAIT_DONE;
        WAIT_DONE: begin
          if (bus.sw_finish) begin
            state        <= LOAD_REF;
            bus.in_ready <= 1'b1;
            busy         <= 1'b0;
            pair_cnt     <= pair_cnt + 8'd1;
          end
        end
        default: state <= LOAD_REF;
      endcase
    end
  end

endmodule

// File: tb/tb_sw_feeder.sv
// Scoreboard bench for sw_feeder: expected symbols are queued at load time and
// popped by a stream monitor as the DUT presents them.
module tb_sw_feeder;

  localparam int unsigned LR = 64;
  localparam int unsigned LQ = 48;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       busy;
  logic       err;
  logic [7:0] pair_cnt;

  sw_feeder_if bus ();

  sw_feeder #(.LEN_REF(LR), .LEN_QUERY(LQ)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .busy     (busy),
    .err      (err),
    .pair_cnt (pair_cnt)
  );

  always #5 clk = ~clk;

  int         tests     = 0;
  int         fails     = 0;
  int         cyc       = 0;
  int         exp_start = -10;
  int         exp_pairs = 0;
  bit         exp_err   = 1'b0;
  bit         aborted   = 1'b0;
  bit         in_run    = 1'b0;
  int         run       = 0;
  logic [3:0] exp_q [$];
  logic [7:0] rb [LR];
  logic [7:0] qb [LQ];

  always @(posedge clk) cyc++;

  // Bit 2 = illegal, bits 1:0 = code.
  function automatic logic [2:0] enc(input logic [7:0] c);
    case (c)
      "A", "a": return 3'b000;
      "C", "c": return 3'b001;
      "G", "g": return 3'b010;
      "T", "t": return 3'b011;
      default:  return 3'b100;
    endcase
  endfunction

  // Stream monitor: latency, contents, run length and idle zeros.
  always @(negedge clk) begin
    logic [3:0] e;
    if (bus.sw_valid === 1'b1) begin
      if (!in_run) begin
        in_run = 1'b1;
        run    = 0;
        tests++;
        if (cyc !== exp_start) begin
          fails++;
          $display("FAIL stream_start: cycle %0d, required %0d", cyc, exp_start);
        end
      end
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL stream_unexpected: sw_valid=1 with nothing expected, run %0d", run);
      end else begin
        e = exp_q.pop_front();
        if ({bus.sw_data_ref, bus.sw_data_query} !== e) begin
          fails++;
          $display("FAIL stream_data k=%0d: ref/qry %0d/%0d, required %0d/%0d",
                   run, bus.sw_data_ref, bus.sw_data_query, e[3:2], e[1:0]);
        end
      end
      run++;
    end else begin
      if (in_run) begin
        in_run = 1'b0;
        if (!aborted) begin
          tests++;
          if (run != LR) begin
            fails++;
            $display("FAIL stream_len: %0d valid cycles, required %0d", run, LR);
          end
        end
        aborted = 1'b0;
      end
      tests++;
      if (bus.sw_data_ref !== 2'd0 || bus.sw_data_query !== 2'd0) begin
        fails++;
        $display("FAIL idle_data: ref/qry %0d/%0d, required 0/0",
                 bus.sw_data_ref, bus.sw_data_query);
      end
    end
  end

  task automatic fill(input string p);
    for (int k = 0; k < LR; k++) rb[k] = p[k % p.len()];
    for (int k = 0; k < LQ; k++) qb[k] = p[k % p.len()];
  endtask

  task automatic fill_random();
    string s = "ACGTacgt";
    for (int k = 0; k < LR; k++) rb[k] = s[$urandom_range(0, 7)];
    for (int k = 0; k < LQ; k++) qb[k] = s[$urandom_range(0, 7)];
  endtask

  task automatic send(input logic [7:0] c, output int nc);
    int g = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready=%b, required 1", bus.in_ready);
    end
    nc           = cyc;
    bus.in_valid = 1'b1;
    bus.in_char  = c;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic idle_check();
    @(negedge clk);
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL stall_ready: in_ready=%b, required 1", bus.in_ready);
    end
  endtask

  task automatic load_pair(input bit toggle, input bit fin_in_qry);
    int         nc;
    logic [2:0] e;
    logic [2:0] f;
    for (int i = 0; i < LR; i++) begin
      send(rb[i], nc);
      e = enc(rb[i]);
      if (i == 0) begin
        exp_err = e[2];
        tests++;
        if (err !== exp_err) begin
          fails++;
          $display("FAIL err_first: err=%b, required %b", err, exp_err);
        end
      end else begin
        exp_err = exp_err | e[2];
      end
      if (toggle) idle_check();
    end
    for (int i = 0; i < LQ; i++) begin
      if (fin_in_qry && i == 5) bus.sw_finish = 1'b1;
      send(qb[i], nc);
      bus.sw_finish = 1'b0;
      e = enc(qb[i]);
      exp_err = exp_err | e[2];
      if (fin_in_qry && i == 5) begin
        tests++;
        if (pair_cnt !== 8'(exp_pairs) || busy !== 1'b1) begin
          fails++;
          $display("FAIL finish_in_qry: pair_cnt=%0d busy=%b, required %0d/1",
                   pair_cnt, busy, exp_pairs);
        end
      end
      if (toggle && i < LQ - 1) idle_check();
    end
    exp_start = nc + 1;
    for (int k = 0; k < LR; k++) begin
      e = enc(rb[k]);
      f = (k < LQ) ? enc(qb[k]) : 3'b000;
      exp_q.push_back({e[1:0], f[1:0]});
    end
  endtask

  task automatic wait_and_finish(input bit gap_pulse);
    int g = 0;
    while (bus.sw_valid !== 1'b1 && g < 400) begin
      @(negedge clk);
      g++;
    end
    while (bus.sw_valid === 1'b1 && g < 400) begin
      @(negedge clk);
      g++;
    end
    if (g >= 400) begin
      tests++;
      fails++;
      $display("FAIL stream_timeout: sw_valid=%b after %0d cycles", bus.sw_valid, g);
    end
    // Now in the GAP cycle; a finish pulse here must be ignored.
    if (gap_pulse) bus.sw_finish = 1'b1;
    @(negedge clk);
    bus.sw_finish = 1'b0;
    tests++;
    if (busy !== 1'b1 || bus.in_ready !== 1'b0 || pair_cnt !== 8'(exp_pairs) ||
        err !== exp_err || exp_q.size() != 0) begin
      fails++;
      $display("FAIL wait_done: busy=%b rdy=%b cnt=%0d err=%b left=%0d, required 1/0/%0d/%b/0",
               busy, bus.in_ready, pair_cnt, err, exp_q.size(), exp_pairs, exp_err);
    end
    bus.sw_finish = 1'b1;
    @(posedge clk);
    #1 bus.sw_finish = 1'b0;
    exp_pairs++;
    tests++;
    if (pair_cnt !== 8'(exp_pairs) || busy !== 1'b0 || bus.in_ready !== 1'b1 || err !== exp_err) begin
      fails++;
      $display("FAIL finish: cnt=%0d busy=%b rdy=%b err=%b, required %0d/0/1/%b",
               pair_cnt, busy, bus.in_ready, err, 8'(exp_pairs), exp_err);
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (bus.in_ready !== 1'b0 || bus.sw_valid !== 1'b0 || busy !== 1'b0 ||
        err !== 1'b0 || pair_cnt !== 8'd0) begin
      fails++;
      $display("FAIL reset_state: rdy=%b vld=%b busy=%b err=%b cnt=%0d, required all 0",
               bus.in_ready, bus.sw_valid, busy, err, pair_cnt);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (bus.in_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: rdy=%b busy=%b, required 1/0", bus.in_ready, busy);
    end
  endtask

  task automatic test_stream_basic();
    fill("ACGT");
    load_pair(1'b0, 1'b0);
    wait_and_finish(1'b0);
  endtask

  task automatic test_stall();
    fill("ACGT");
    load_pair(1'b1, 1'b0);
    wait_and_finish(1'b0);
  endtask

  task automatic test_finish_ignored();
    fill("GATC");
    load_pair(1'b0, 1'b1);
    wait_and_finish(1'b1);
  endtask

  task automatic test_illegal();
    fill("TGCA");
    qb[10] = "N";
    load_pair(1'b0, 1'b0);
    wait_and_finish(1'b0);
    // Illegal first character of the next pair keeps err set.
    fill("CATG");
    rb[0] = "x";
    load_pair(1'b0, 1'b0);
    wait_and_finish(1'b0);
  endtask

  task automatic test_reset_mid();
    int k = -1;
    int g = 0;
    fill("AGCT");
    load_pair(1'b0, 1'b0);
    while (k < 30 && g < 200) begin
      @(negedge clk);
      g++;
      if (bus.sw_valid === 1'b1) k++;
    end
    aborted = 1'b1;
    reset   = 1'b0;
    #1;
    tests++;
    if (bus.sw_valid !== 1'b0 || bus.sw_data_ref !== 2'd0 || bus.sw_data_query !== 2'd0 ||
        bus.in_ready !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || pair_cnt !== 8'd0) begin
      fails++;
      $display("FAIL mid_reset: k=%0d vld=%b rdy=%b busy=%b err=%b cnt=%0d, required 30 and all 0",
               k, bus.sw_valid, bus.in_ready, busy, err, pair_cnt);
    end
    exp_q.delete();
    exp_pairs = 0;
    exp_err   = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (bus.in_ready !== 1'b1 || bus.sw_valid !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_release: rdy=%b vld=%b, required 1/0", bus.in_ready, bus.sw_valid);
    end
    fill("TTGA");
    load_pair(1'b0, 1'b0);
    wait_and_finish(1'b0);
  endtask

  task automatic test_lower_wrap();
    fill("acgt");
    load_pair(1'b0, 1'b0);
    wait_and_finish(1'b0);
    while (exp_pairs < 256) begin
      fill_random();
      load_pair(1'b0, 1'b0);
      wait_and_finish(1'b0);
    end
    tests++;
    if (pair_cnt !== 8'd0) begin
      fails++;
      $display("FAIL pair_wrap: pair_cnt=%0d, required 0", pair_cnt);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_char   = 8'h00;
    bus.sw_finish = 1'b0;
    test_reset();
    test_stream_basic();
    test_stall();
    test_finish_ignored();
    test_illegal();
    test_reset_mid();
    test_lower_wrap();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not complete, %0d failed so far", fails);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sw_feeder.md
SW_FEEDER -- requirements
Module: sw_feeder

Interface
REQ-001 Parameter LEN_REF, default 64, reference symbols per alignment pair.
REQ-002 Parameter LEN_QUERY, default 48, query symbols per alignment pair; SHALL be at most LEN_REF.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  host ASCII character present.
REQ-006 in_char  input  8  host ASCII nucleotide (A/C/G/T, either case).
REQ-007 in_ready  output  1  feeder accepts in_char this cycle.
REQ-008 sw_valid  output  1  symbol stream valid toward aligner.
REQ-009 sw_data_ref  output  2  encoded reference symbol.
REQ-010 sw_data_query  output  2  encoded query symbol.
REQ-011 sw_finish  input  1  aligner done pulse.
REQ-012 busy  output  1  a pair is loading, streaming or awaiting sw_finish.
REQ-013 err  output  1  sticky: an illegal character occurred in the current pair.
REQ-014 pair_cnt  output  8  completed pairs, wraps 255->0.

Function
REQ-015 Encoding SHALL be A/a=0, C/c=1, G/g=2, T/t=3; any other byte SHALL be stored as 0 and SHALL set err.
REQ-016 A transfer occurs when in_valid and in_ready are both high; in_ready SHALL depend only on state, not on in_valid.
REQ-017 States: LOAD_REF, LOAD_QRY, STREAM, GAP, WAIT_DONE.
REQ-018 LOAD_REF: in_ready=1; each transfer SHALL be written to ref buffer[idx]; after transfer LEN_REF-1 -> LOAD_QRY, idx=0.
REQ-019 LOAD_QRY: in_ready=1; each transfer SHALL be written to query buffer[idx]; after transfer LEN_QUERY-1 -> STREAM, idx=0.
REQ-020 STREAM: in_ready=0; sw_valid=1 for exactly LEN_REF consecutive cycles; in cycle k, sw_data_ref=ref[k]; sw_data_query=query[k] for k<LEN_QUERY, else 0.
REQ-021 The first STREAM cycle SHALL be the cycle after the final query transfer (1-cycle latency).
REQ-022 After cycle LEN_REF-1 -> GAP; sw_valid=0 for at least one cycle, then -> WAIT_DONE.
REQ-023 WAIT_DONE: sw_valid=0, in_ready=0; on sw_finish=1 -> LOAD_REF and pair_cnt increments.
REQ-024 sw_finish SHALL be ignored in every state except WAIT_DONE, including a sw_finish in the GAP cycle.
REQ-025 busy SHALL be 0 only in LOAD_REF with idx=0.
REQ-026 err SHALL clear on the first transfer of a new pair, which occurs in LOAD_REF at idx=0.
REQ-027 An illegal character on that first transfer SHALL leave err=1.
REQ-028 When sw_valid=0, sw_data_ref and sw_data_query SHALL be 0.
REQ-029 Stalls (in_valid=0) during loading SHALL hold idx and buffers; there is no timeout.

Reset
REQ-030 While reset=0: state=LOAD_REF, idx=0, sw_valid=0, sw_data_*=0, err=0, pair_cnt=0, busy=0.
REQ-031 Under reset, in_ready SHALL be 0.
REQ-032 Buffer contents need no reset.
REQ-033 Reset asserted mid-stream SHALL drop sw_valid asynchronously.
REQ-034 After a mid-stream reset, the next pair SHALL reload both sequences.
REQ-035 in_ready SHALL rise the first clock after reset deasserts.

Structure
REQ-036 Shared package sw_pkg SHALL hold LEN_REF/LEN_QUERY defaults, the 2-bit nucleotide encoding constants and the feeder state encoding.
REQ-037 Character decoding SHALL be a combinational sub-module nt_encoder (in: 8-bit char; out: 2-bit code, illegal flag).
REQ-038 The index counter SHALL be $clog2(LEN_REF) bits and shared by load and stream.

Verification
REQ-039 Reset, then 64 ref chars "ACGT"x16 and 48 query chars "ACGT"x12, back-to-back -> sw_valid high 64 cycles starting one cycle after the last query transfer; data_ref k = k mod 4; data_query = k mod 4 for k<48 and 0 for k>=48; err=0.
REQ-040 Same data with in_valid toggled every other cycle -> identical sw stream; in_ready stays 1 through loading.
REQ-041 Query char 10 = 'N' -> query[10] streams as 0; err=1 until the first transfer of the next pair.
REQ-042 sw_finish pulses during LOAD_QRY and during GAP -> ignored; a pulse in WAIT_DONE -> pair_cnt 0->1, busy=0, in_ready=1 next cycle.
REQ-043 reset pulled low at stream cycle 30 -> sw_valid=0 immediately; after release, a full new pair is required before sw_valid rises.
REQ-044 Lowercase "acgt" input -> same codes as uppercase; 256 completed pairs -> pair_cnt wraps to 0.
